// File: rtl/cache_line_fill.sv
// Assembles NUM_BEATS memory beats into one cache line and writes it to the data memory.
// Optional macro FILL_LAST_CHECK_EN enables beat-framing checks on mem_last_in (sticky fill_err_out).
module cache_line_fill #(
    parameter int PIXEL_BITS      = 8,
    parameter int CACHE_LINE_WDTH = 48,
    parameter int BEAT_WDTH       = 128,
    parameter int LINE_ADDR_WDTH  = 7
) (
    input  logic                                  clk,
    input  logic                                  reset,
    input  logic                                  fill_req_in,
    input  logic [LINE_ADDR_WDTH-1:0]             fill_addr_in,
    output logic                                  fill_ready_out,
    input  logic                                  mem_valid_in,
    input  logic [BEAT_WDTH-1:0]                  mem_data_in,
    input  logic                                  mem_last_in,
    output logic                                  mem_ready_out,
    output logic [LINE_ADDR_WDTH-1:0]             dm_addr_out,
    output logic [PIXEL_BITS*CACHE_LINE_WDTH-1:0] dm_w_data_out,
    output logic                                  dm_w_en_out,
    output logic                                  fill_done_out,
    output logic                                  fill_err_out
);

    localparam int LINE_BITS = PIXEL_BITS * CACHE_LINE_WDTH;
    localparam int NUM_BEATS = LINE_BITS / BEAT_WDTH;
    localparam int CNT_W     = (NUM_BEATS > 1) ? $clog2(NUM_BEATS) : 1;
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(NUM_BEATS - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        WRITE   = 2'd2
    } state_t;

    state_t                    state_r;
    logic [CNT_W-1:0]          beat_cnt_r;
    logic [LINE_BITS-1:0]      line_r;
    logic [LINE_ADDR_WDTH-1:0] addr_r;
    logic                      fill_ready_r;
    logic                      mem_ready_r;
    logic                      w_en_r;
    logic                      done_r;
    logic                      err_r;
    logic                      beat_fire_s;
    logic                      last_err_s;

    assign beat_fire_s = mem_valid_in & mem_ready_r;

    // Framing check: the last marker must be set on exactly the final beat of a line.
    always_comb begin
        last_err_s = 1'b0;
`ifdef FILL_LAST_CHECK_EN
        if (beat_fire_s) begin
            last_err_s = mem_last_in ^ (beat_cnt_r == LAST_BEAT);
        end else begin
            last_err_s = 1'b0;
        end
`else
        last_err_s = mem_last_in & 1'b0;
`endif
    end

    // Fill FSM; all outputs are registered alongside the state.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r      <= IDLE;
            beat_cnt_r   <= '0;
            line_r       <= '0;
            addr_r       <= '0;
            fill_ready_r <= 1'b1;
            mem_ready_r  <= 1'b0;
            w_en_r       <= 1'b0;
            done_r       <= 1'b0;
            err_r        <= 1'b0;
        end else begin
            err_r <= err_r | last_err_s;
            case (state_r)
                IDLE: begin
                    w_en_r <= 1'b0;
                    done_r <= 1'b0;
                    if (fill_req_in) begin
                        addr_r       <= fill_addr_in;
                        beat_cnt_r   <= '0;
                        state_r      <= COLLECT;
                        fill_ready_r <= 1'b0;
                        mem_ready_r  <= 1'b1;
                    end
                end
                COLLECT: begin
                    if (beat_fire_s) begin
                        line_r[beat_cnt_r*BEAT_WDTH +: BEAT_WDTH] <= mem_data_in;
                        if (beat_cnt_r == LAST_BEAT) begin
                            state_r     <= WRITE;
                            mem_ready_r <= 1'b0;
                            w_en_r      <= 1'b1;
                            done_r      <= 1'b1;
                        end else begin
                            beat_cnt_r <= beat_cnt_r + CNT_W'(1);
                        end
                    end
                end
                WRITE: begin
                    state_r      <= IDLE;
                    w_en_r       <= 1'b0;
                    done_r       <= 1'b0;
                    fill_ready_r <= 1'b1;
                end
                default: begin
                    state_r      <= IDLE;
                    beat_cnt_r   <= '0;
                    fill_ready_r <= 1'b1;
                    mem_ready_r  <= 1'b0;
                    w_en_r       <= 1'b0;
                    done_r       <= 1'b0;
                end
            endcase
        end
    end

    assign fill_ready_out = fill_ready_r;
    assign mem_ready_out  = mem_ready_r;
    assign dm_addr_out    = addr_r;
    assign dm_w_data_out  = line_r;
    assign dm_w_en_out    = w_en_r;
    assign fill_done_out  = done_r;
    assign fill_err_out   = err_r;

endmodule

// File: tb/tb_cache_line_fill.sv
// Directed self-checking bench for cache_line_fill (default parameters, 3 beats of 128 bits).
module tb_cache_line_fill;

    logic         clk;
    logic         reset;
    logic         fill_req_in;
    logic [6:0]   fill_addr_in;
    logic         fill_ready_out;
    logic         mem_valid_in;
    logic [127:0] mem_data_in;
    logic         mem_last_in;
    logic         mem_ready_out;
    logic [6:0]   dm_addr_out;
    logic [383:0] dm_w_data_out;
    logic         dm_w_en_out;
    logic         fill_done_out;
    logic         fill_err_out;

    int checks = 0;
    int errors = 0;
    int wr_count = 0;

    cache_line_fill dut (
        .clk(clk), .reset(reset),
        .fill_req_in(fill_req_in), .fill_addr_in(fill_addr_in), .fill_ready_out(fill_ready_out),
        .mem_valid_in(mem_valid_in), .mem_data_in(mem_data_in), .mem_last_in(mem_last_in),
        .mem_ready_out(mem_ready_out), .dm_addr_out(dm_addr_out), .dm_w_data_out(dm_w_data_out),
        .dm_w_en_out(dm_w_en_out), .fill_done_out(fill_done_out), .fill_err_out(fill_err_out)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Counts write cycles seen by the data memory.
    always @(posedge clk) begin
        if (dm_w_en_out === 1'b1) wr_count <= wr_count + 1;
    end

    task automatic step();
        @(negedge clk);
    endtask

    task automatic test_reset();
        reset = 1'b1; fill_req_in = 1'b0; fill_addr_in = 7'd0;
        mem_valid_in = 1'b0; mem_data_in = 128'd0; mem_last_in = 1'b0;
        step(); step();
        reset = 1'b0;
        checks++; if (fill_ready_out !== 1'b1) begin errors++; $display("FAIL rst_fill_ready got %b exp 1", fill_ready_out); end
        checks++; if (mem_ready_out !== 1'b0) begin errors++; $display("FAIL rst_mem_ready got %b exp 0", mem_ready_out); end
        checks++; if (dm_w_en_out !== 1'b0) begin errors++; $display("FAIL rst_w_en got %b exp 0", dm_w_en_out); end
        checks++; if (fill_done_out !== 1'b0) begin errors++; $display("FAIL rst_done got %b exp 0", fill_done_out); end
        checks++; if (fill_err_out !== 1'b0) begin errors++; $display("FAIL rst_err got %b exp 0", fill_err_out); end
        checks++; if (dm_addr_out !== 7'd0) begin errors++; $display("FAIL rst_addr got %0h exp 0", dm_addr_out); end
        checks++; if (dm_w_data_out !== 384'd0) begin errors++; $display("FAIL rst_data got %h exp 0", dm_w_data_out); end
    endtask

    task automatic test_basic();
        fill_req_in = 1'b1; fill_addr_in = 7'd5;
        step();
        fill_req_in = 1'b0; fill_addr_in = 7'd0;
        checks++; if (mem_ready_out !== 1'b1) begin errors++; $display("FAIL basic_mem_ready got %b exp 1", mem_ready_out); end
        checks++; if (fill_ready_out !== 1'b0) begin errors++; $display("FAIL basic_fill_ready got %b exp 0", fill_ready_out); end
        mem_valid_in = 1'b1; mem_data_in = 128'h1; step();
        mem_data_in = 128'h2; step();
        mem_data_in = 128'h3; step();
        mem_valid_in = 1'b0; mem_data_in = 128'd0;
        checks++; if (dm_w_en_out !== 1'b1) begin errors++; $display("FAIL basic_w_en got %b exp 1", dm_w_en_out); end
        checks++; if (fill_done_out !== 1'b1) begin errors++; $display("FAIL basic_done got %b exp 1", fill_done_out); end
        checks++; if (dm_addr_out !== 7'd5) begin errors++; $display("FAIL basic_addr got %0h exp 5", dm_addr_out); end
        checks++; if (dm_w_data_out !== {128'h3, 128'h2, 128'h1}) begin errors++; $display("FAIL basic_data got %h", dm_w_data_out); end
        checks++; if (mem_ready_out !== 1'b0) begin errors++; $display("FAIL basic_write_mem_ready got %b exp 0", mem_ready_out); end
        step();
        checks++; if (fill_done_out !== 1'b0) begin errors++; $display("FAIL basic_done_pulse got %b exp 0", fill_done_out); end
        checks++; if (dm_w_en_out !== 1'b0) begin errors++; $display("FAIL basic_w_en_pulse got %b exp 0", dm_w_en_out); end
        checks++; if (fill_ready_out !== 1'b1) begin errors++; $display("FAIL basic_ready_again got %b exp 1", fill_ready_out); end
    endtask

    task automatic test_gaps();
        int wr_before;
        wr_before = wr_count;
        fill_req_in = 1'b1; fill_addr_in = 7'd7;
        step();
        fill_req_in = 1'b0;
        for (int k = 0; k < 3; k++) begin
            for (int g = 0; g < 2; g++) begin
                mem_valid_in = 1'b0; mem_data_in = 128'hdead;
                checks++; if (mem_ready_out !== 1'b1 || dm_w_en_out !== 1'b0) begin
                    errors++; $display("FAIL gap_ready k=%0d g=%0d got ready %b w_en %b exp 1 0", k, g, mem_ready_out, dm_w_en_out);
                end
                step();
            end
            mem_valid_in = 1'b1; mem_data_in = 128'h10 + 128'(k);
            checks++; if (mem_ready_out !== 1'b1) begin errors++; $display("FAIL gap_beat_ready k=%0d got %b exp 1", k, mem_ready_out); end
            step();
        end
        mem_valid_in = 1'b0; mem_data_in = 128'd0;
        checks++; if (dm_w_en_out !== 1'b1 || dm_addr_out !== 7'd7) begin
            errors++; $display("FAIL gap_write got w_en %b addr %0h exp 1 7", dm_w_en_out, dm_addr_out);
        end
        checks++; if (dm_w_data_out !== {128'h12, 128'h11, 128'h10}) begin errors++; $display("FAIL gap_data got %h", dm_w_data_out); end
        step();
        checks++; if (wr_count !== wr_before + 1) begin errors++; $display("FAIL gap_write_count got %0d exp %0d", wr_count, wr_before + 1); end
    endtask

    task automatic test_ignore_req();
        fill_req_in = 1'b1; fill_addr_in = 7'd5;
        step();
        fill_addr_in = 7'd9;
        mem_valid_in = 1'b1; mem_data_in = 128'h51; step();
        mem_data_in = 128'h52; step();
        mem_data_in = 128'h53; step();
        mem_valid_in = 1'b0;
        checks++; if (dm_w_en_out !== 1'b1 || dm_addr_out !== 7'd5) begin
            errors++; $display("FAIL ignore_write got w_en %b addr %0h exp 1 5", dm_w_en_out, dm_addr_out);
        end
        fill_req_in = 1'b0;
        step();
        step();
        checks++; if (mem_ready_out !== 1'b0 || fill_ready_out !== 1'b1) begin
            errors++; $display("FAIL ignore_no_queue got mem_ready %b fill_ready %b exp 0 1", mem_ready_out, fill_ready_out);
        end
        fill_req_in = 1'b1; fill_addr_in = 7'd9;
        step();
        fill_req_in = 1'b0;
        checks++; if (mem_ready_out !== 1'b1) begin errors++; $display("FAIL ignore_new_req got %b exp 1", mem_ready_out); end
        mem_valid_in = 1'b1; mem_data_in = 128'h91; step();
        mem_data_in = 128'h92; step();
        mem_data_in = 128'h93; step();
        mem_valid_in = 1'b0;
        checks++; if (dm_w_en_out !== 1'b1 || dm_addr_out !== 7'd9 || dm_w_data_out !== {128'h93, 128'h92, 128'h91}) begin
            errors++; $display("FAIL ignore_second_write got w_en %b addr %0h data %h", dm_w_en_out, dm_addr_out, dm_w_data_out);
        end
        step();
    endtask

    task automatic test_reset_abort();
        int wr_before;
        wr_before = wr_count;
        fill_req_in = 1'b1; fill_addr_in = 7'd3;
        step();
        fill_req_in = 1'b0;
        mem_valid_in = 1'b1; mem_data_in = 128'haa; step();
        mem_data_in = 128'hbb; step();
        reset = 1'b1; mem_valid_in = 1'b0;
        step();
        reset = 1'b0;
        checks++; if (fill_ready_out !== 1'b1 || mem_ready_out !== 1'b0 || dm_addr_out !== 7'd0 || dm_w_data_out !== 384'd0) begin
            errors++; $display("FAIL abort_state got ready %b mem_ready %b addr %0h data %h", fill_ready_out, mem_ready_out, dm_addr_out, dm_w_data_out);
        end
        step(); step(); step();
        checks++; if (wr_count !== wr_before) begin errors++; $display("FAIL abort_no_write got %0d exp %0d", wr_count, wr_before); end
        fill_req_in = 1'b1; fill_addr_in = 7'd2;
        step();
        fill_req_in = 1'b0;
        mem_valid_in = 1'b1; mem_data_in = 128'h21; step();
        mem_data_in = 128'h22; step();
        mem_data_in = 128'h23; step();
        mem_valid_in = 1'b0;
        checks++; if (dm_w_en_out !== 1'b1 || dm_addr_out !== 7'd2 || dm_w_data_out !== {128'h23, 128'h22, 128'h21}) begin
            errors++; $display("FAIL abort_refill got w_en %b addr %0h data %h", dm_w_en_out, dm_addr_out, dm_w_data_out);
        end
        step();
    endtask

    task automatic test_idle_valid();
        int wr_before;
        wr_before = wr_count;
        mem_valid_in = 1'b1;
        for (int i = 0; i < 3; i++) begin
            mem_data_in = 128'hffff_ffff_ffff_ffff + 128'(i);
            mem_last_in = i[0];
            step();
        end
        mem_valid_in = 1'b0; mem_last_in = 1'b0;
        checks++; if (dm_w_data_out !== {128'h23, 128'h22, 128'h21}) begin errors++; $display("FAIL idle_line got %h", dm_w_data_out); end
        checks++; if (mem_ready_out !== 1'b0 || fill_ready_out !== 1'b1) begin
            errors++; $display("FAIL idle_state got mem_ready %b fill_ready %b exp 0 1", mem_ready_out, fill_ready_out);
        end
        step();
        checks++; if (wr_count !== wr_before) begin errors++; $display("FAIL idle_no_write got %0d exp %0d", wr_count, wr_before); end
        checks++; if (fill_err_out !== 1'b0) begin errors++; $display("FAIL idle_err got %b exp 0", fill_err_out); end
    endtask

    task automatic test_last_check();
        logic exp_err;
`ifdef FILL_LAST_CHECK_EN
        exp_err = 1'b1;
`else
        exp_err = 1'b0;
`endif
        fill_req_in = 1'b1; fill_addr_in = 7'd4;
        step();
        fill_req_in = 1'b0;
        mem_valid_in = 1'b1; mem_data_in = 128'h41; mem_last_in = 1'b0; step();
        checks++; if (fill_err_out !== 1'b0) begin errors++; $display("FAIL last_err_early got %b exp 0", fill_err_out); end
        mem_data_in = 128'h42; mem_last_in = 1'b1; step();
        checks++; if (fill_err_out !== exp_err) begin errors++; $display("FAIL last_err_set got %b exp %b", fill_err_out, exp_err); end
        mem_data_in = 128'h43; mem_last_in = 1'b1; step();
        mem_valid_in = 1'b0; mem_last_in = 1'b0;
        checks++; if (dm_w_en_out !== 1'b1 || dm_addr_out !== 7'd4 || dm_w_data_out !== {128'h43, 128'h42, 128'h41}) begin
            errors++; $display("FAIL last_write got w_en %b addr %0h data %h", dm_w_en_out, dm_addr_out, dm_w_data_out);
        end
        step(); step();
        checks++; if (fill_err_out !== exp_err) begin errors++; $display("FAIL last_err_sticky got %b exp %b", fill_err_out, exp_err); end
        reset = 1'b1; step(); reset = 1'b0;
        checks++; if (fill_err_out !== 1'b0) begin errors++; $display("FAIL last_err_clear got %b exp 0", fill_err_out); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_gaps();
        test_ignore_req();
        test_reset_abort();
        test_idle_valid();
        test_last_check();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/cache_line_fill.md
CACHE_LINE_FILL -- requirements
Module: cache_line_fill

Interface
REQ-001 Parameter PIXEL_BITS, default 8, bits per pixel.
REQ-002 Parameter CACHE_LINE_WDTH, default 48, pixels per cache line.
REQ-003 Parameter BEAT_WDTH, default 128, memory beat width in bits; PIXEL_BITS*CACHE_LINE_WDTH SHALL be an integer multiple of BEAT_WDTH; NUM_BEATS = PIXEL_BITS*CACHE_LINE_WDTH/BEAT_WDTH (default 3).
REQ-004 Parameter LINE_ADDR_WDTH, default 7, data-memory line address width.
REQ-005 Ports (clock and reset first):
- clk  input  1  sole clock; all logic on rising edge.
- reset  input  1  synchronous, active-high reset.
- fill_req_in  input  1  start a line fill.
- fill_addr_in  input  LINE_ADDR_WDTH  destination line address, sampled with fill_req_in.
- fill_ready_out  output  1  block idle and able to accept a request.
- mem_valid_in  input  1  memory beat valid.
- mem_data_in  input  BEAT_WDTH  memory beat data.
- mem_last_in  input  1  final beat marker (used only under FILL_LAST_CHECK_EN).
- mem_ready_out  output  1  block accepts a beat this cycle.
- dm_addr_out  output  LINE_ADDR_WDTH  data-memory address.
- dm_w_data_out  output  PIXEL_BITS*CACHE_LINE_WDTH  assembled line.
- dm_w_en_out  output  1  data-memory write enable.
- fill_done_out  output  1  one-cycle fill-complete pulse.
- fill_err_out  output  1  sticky beat-framing error flag.

Function
REQ-006 The FSM SHALL have states IDLE, COLLECT and WRITE.
REQ-007 IDLE: fill_ready_out=1; when fill_req_in=1, the block SHALL latch fill_addr_in, clear the beat counter and enter COLLECT on the next cycle.
REQ-008 A beat SHALL be accepted only when mem_valid_in=1 and mem_ready_out=1; mem_ready_out SHALL be 1 only in COLLECT.
REQ-009 Accepted beat k (k = 0..NUM_BEATS-1, counted from 0) SHALL be stored at line bits [k*BEAT_WDTH +: BEAT_WDTH]; beat 0 occupies the LSBs.
REQ-010 The cycle after beat NUM_BEATS-1 is accepted, the FSM SHALL be in WRITE.
REQ-011 WRITE SHALL last exactly one cycle; dm_w_en_out=1, fill_done_out=1, dm_addr_out=latched address and dm_w_data_out=assembled line; the next state SHALL be IDLE.
REQ-012 dm_w_en_out SHALL be 0 in every state except WRITE, so the downstream data memory performs reads in all other cycles.
REQ-013 fill_req_in SHALL be ignored while not in IDLE; no request queueing.
REQ-014 mem_valid_in outside COLLECT SHALL be ignored and SHALL not alter line contents.
REQ-015 Bubbles (mem_valid_in=0) in COLLECT SHALL stall the counter without limit; no timeout.
REQ-016 Minimum latency: request at cycle 0, beats at cycles 1..NUM_BEATS, write/done at cycle NUM_BEATS+1, fill_ready_out=1 again at cycle NUM_BEATS+2.
REQ-017 Outside WRITE, dm_addr_out SHALL hold the latched address; dm_w_data_out holds the line register and has no meaning when dm_w_en_out=0.

Reset
REQ-018 With reset=1 at a rising edge: state IDLE, beat counter 0, line register 0, latched address 0, fill_err_out 0.
REQ-019 Reset values: fill_ready_out=1, mem_ready_out=0, dm_w_en_out=0, fill_done_out=0, fill_err_out=0, dm_addr_out=0, dm_w_data_out=0.
REQ-020 Reset during COLLECT or WRITE SHALL abandon the fill; no write is issued.

Configuration
REQ-021 Macro FILL_LAST_CHECK_EN, when defined: on each accepted beat, mem_last_in=1 with k<NUM_BEATS-1, or mem_last_in=0 with k=NUM_BEATS-1, SHALL set fill_err_out=1 (sticky until reset); the fill still completes after NUM_BEATS beats.
REQ-022 Without FILL_LAST_CHECK_EN: mem_last_in is ignored and fill_err_out is held at constant 0.

Verification
REQ-023 Reset, then request addr 5 with beats 0x..01, 0x..02, 0x..03 back-to-back -> write at cycle 4 to addr 5 with line {B3,B2,B1}, fill_done_out high for exactly 1 cycle.
REQ-024 Beats interleaved with 2-cycle valid gaps -> single write after the 3rd beat only; mem_ready_out high throughout COLLECT.
REQ-025 Second fill_req_in (addr 9) during COLLECT of addr 5 -> ignored; only addr 5 is written; a new request is accepted once fill_ready_out=1.
REQ-026 reset asserted after 2 beats -> no dm_w_en_out pulse; a following fill to addr 2 writes only its own beats.
REQ-027 FILL_LAST_CHECK_EN defined, mem_last_in=1 on beat 1 -> fill_err_out=1 from the next cycle, write still issued after beat 2; macro undefined -> fill_err_out stays 0.
REQ-028 mem_valid_in pulses while IDLE -> line register unchanged and no write issued.
